seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, 32, datapath width; power of two, 8..64.
REQ-002 SHALL have derived localparam SHAMT_W, $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request; accepted at a rising edge when state is IDLE or DONE.
REQ-006 SHALL have port aluop  in  2  operation class: 00 add, 01 sub, 11 and, 10 decode funct.
REQ-007 SHALL have port funct  in  6  R-type function field.
REQ-008 SHALL have ports a, b  in  WIDTH  operands; sampled only at acceptance.
REQ-009 SHALL have port busy  out  1  high while state is RUN.
REQ-010 SHALL have port done  out  1  one-cycle pulse; result, zero and illegal are valid.
REQ-011 SHALL have port result  out  WIDTH  registered result; held until the next acceptance.
REQ-012 SHALL have port zero  out  1  result == 0.
REQ-013 SHALL have port illegal  out  1  last accepted operation was undecodable; held like result.

Function
REQ-014 SHALL decode funct when aluop=10: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000010 srl, 000000 sll, 011000 mul; any other funct is illegal.
REQ-015 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-016 SHALL accept start in IDLE or DONE, giving back-to-back issue; start in RUN SHALL be ignored and not queued.
REQ-017 SHALL implement single-step ops add, sub, and, or, slt and illegal with IDLE/DONE -> DONE at acceptance, so done is high in the cycle after acceptance (latency 1).
REQ-018 SHALL compute add/sub modulo 2^WIDTH; slt SHALL be a signed compare giving result 1 or 0, zero-extended.
REQ-019 SHALL implement srl/sll iteratively, one bit per RUN cycle, with shift amount n = b[SHAMT_W-1:0] and upper b bits ignored; latency SHALL be n+1.
REQ-020 SHALL complete a shift with n=0 like a single-step op, with result = a.
REQ-021 SHALL implement mul as shift-add, one multiplier bit per RUN cycle, WIDTH steps, latency WIDTH+1; result SHALL be the low WIDTH bits of a*b.
REQ-022 SHALL use a SHAMT_W+1-bit step counter loaded at acceptance and decremented in RUN; RUN -> DONE when the counter reaches 1 at the edge.
REQ-023 SHALL leave DONE after exactly one cycle: to IDLE if no start, or per REQ-017/019/021 if start is accepted.
REQ-024 SHALL complete an illegal op with illegal=1, result=0, zero=1; any legal completion SHALL clear illegal.
REQ-025 SHALL drive zero combinationally from the result register.
REQ-026 SHALL keep result unchanged during RUN and load it only on the transition into DONE.

Reset
REQ-027 SHALL, while reset is high at an edge, force state IDLE, result 0, zero 1, illegal 0, done 0, busy 0 and counter 0.
REQ-028 SHALL abort any operation on reset mid-RUN, with no done pulse; reset SHALL take priority over start.

Structure
REQ-029 SHALL place the alucontrol enum in shared package alu_pkg: and 0000, or 0001, add 0010, sll 0011, srl 0111, mul 0101, sub 1010, slt 1011, illegal 1111.
REQ-030 SHALL place the funct constants and the FSM state typedef in alu_pkg.
REQ-031 SHALL use one combinational sub-module, alu_ctrl_dec (aluop, funct -> 4-bit alucontrol), instantiated once.

Verification
REQ-032 SHALL cover: WIDTH=32, aluop=10, funct=100010, a=5, b=7 -> done one cycle later, result=32'hFFFFFFFE, zero=0.
REQ-033 SHALL cover: funct=000010, a=32'h80000000, b=32'h00000024 (n=4) -> busy for 4 cycles, done at cycle 5, result=32'h08000000.
REQ-034 SHALL cover: funct=011000, a=32'hFFFFFFFF, b=3 -> done at cycle 33, result=32'hFFFFFFFD; start pulsed during RUN is ignored.
REQ-035 SHALL cover: funct=111111 -> done at cycle 1, illegal=1, result=0, zero=1; then aluop=00, a=b=0 -> illegal=0, zero=1.
REQ-036 SHALL cover: reset asserted during mul RUN -> next cycle IDLE, busy=0, result=0, and no done pulse ever appears.
REQ-037 SHALL cover: slt, a=-1, b=1 -> result 1; start held high in the DONE cycle with an add issues back-to-back, giving done pulses on consecutive cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: control encodings,
// R-type funct values and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_MUL = 4'b0101,
    ALU_SRL = 4'b0111,
    ALU_SUB = 4'b1010,
    ALU_SLT = 4'b1011,
    ALU_ILL = 4'b1111
  } alu_ctrl_e;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_MUL = 6'b011000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps aluop/funct to an alucontrol code.
// Purely combinational.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output alu_ctrl_e  alucontrol
);

  alu_ctrl_e fdec;

  always_comb begin
    fdec = ALU_ILL;
    unique case (1'b1)
      (funct == F_ADD): fdec = ALU_ADD;
      (funct == F_SUB): fdec = ALU_SUB;
      (funct == F_AND): fdec = ALU_AND;
      (funct == F_OR):  fdec = ALU_OR;
      (funct == F_SLT): fdec = ALU_SLT;
      (funct == F_SRL): fdec = ALU_SRL;
      (funct == F_SLL): fdec = ALU_SLL;
      (funct == F_MUL): fdec = ALU_MUL;
      default:          fdec = ALU_ILL;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ILL;
    unique case (1'b1)
      (aluop == 2'b00): alucontrol = ALU_ADD;
      (aluop == 2'b01): alucontrol = ALU_SUB;
      (aluop == 2'b11): alucontrol = ALU_AND;
      default:          alucontrol = fdec;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic ops, iterative shifts
// (one bit per cycle) and a shift-add multiplier.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] CNT_ONE = (SHAMT_W+1)'(1);
  localparam logic [SHAMT_W:0] CNT_MUL = (SHAMT_W+1)'(WIDTH);

  alu_ctrl_e ctrl;
  alu_ctrl_e op;
  state_e    state;
  state_e    state_nxt;

  logic [SHAMT_W:0]   cnt;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   work_nxt;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   run_res;
  logic [WIDTH-1:0]   one_res;
  logic [SHAMT_W-1:0] n;
  logic               accept;
  logic               is_shift;
  logic               is_mul;
  logic               multi;
  logic               last;

  alu_ctrl_dec u_dec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (ctrl)
  );

  assign n        = b[SHAMT_W-1:0];
  assign accept   = start && (state != S_RUN);
  assign is_shift = (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  assign is_mul   = (ctrl == ALU_MUL);
  assign multi    = is_mul || (is_shift && (n != '0));
  assign last     = (cnt == CNT_ONE);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign zero = (result == '0);

  always_comb begin
    one_res = '0;
    unique case (ctrl)
      ALU_ADD: one_res = a + b;
      ALU_SUB: one_res = a - b;
      ALU_AND: one_res = a & b;
      ALU_OR:  one_res = a | b;
      ALU_SLT: one_res = {{(WIDTH-1){1'b0}},
                          ($signed(a) < $signed(b))};
      ALU_SLL: one_res = a;
      ALU_SRL: one_res = a;
      default: one_res = '0;
    endcase
  end

  // work holds the value being shifted, or the multiplicand
  always_comb begin
    work_nxt = (op == ALU_SRL) ? (work >> 1) : (work << 1);
    acc_nxt  = acc + (mplier[0] ? work : '0);
    run_res  = (op == ALU_MUL) ? acc_nxt : work_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (!accept)    state_nxt = S_IDLE;
        else if (multi) state_nxt = S_RUN;
        else            state_nxt = S_DONE;
      end
      S_RUN:   if (last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      illegal <= 1'b0;
      cnt     <= '0;
      op      <= ALU_ADD;
      work    <= '0;
      acc     <= '0;
      mplier  <= '0;
    end else if (accept) begin
      op     <= ctrl;
      work   <= a;
      acc    <= '0;
      mplier <= b;
      if (is_mul)        cnt <= CNT_MUL;
      else if (is_shift) cnt <= {1'b0, n};
      else               cnt <= '0;
      if (!multi) begin
        result  <= one_res;
        illegal <= (ctrl == ALU_ILL);
      end
    end else if (state == S_RUN) begin
      work   <= work_nxt;
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_ONE;
      if (last) begin
        result  <= run_res;
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
// Outputs are sampled on the falling edge.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int ntests = 0;
  int nfail  = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .aluop   (aluop),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [5:0] f,
                       input logic [31:0] xa,
                       input logic [31:0] xb);
    @(negedge clk);
    aluop = op; funct = f; a = xa; b = xb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat counts falling edges from acceptance to the done pulse
  task automatic wait_done(input int poke,
                           output int lat,
                           output int nbusy);
    lat = 0;
    nbusy = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) break;
      if (lat >= 200) begin
        check("timeout", {63'd0, done}, 64'd1);
        break;
      end
      if (lat == poke) begin
        start = 1'b1; aluop = 2'b00; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    int lat;
    int nb;
    int ndone;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_illegal", illegal, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);

    issue(2'b10, F_SUB, 32'd5, 32'd7);
    wait_done(0, lat, nb);
    check("sub_lat", lat, 1);
    check("sub_res", result, 32'hFFFFFFFE);
    check("sub_zero", zero, 0);
    @(negedge clk);
    check("sub_done_drop", done, 0);
    check("sub_hold", result, 32'hFFFFFFFE);

    vt.push_back('{2'b00, 6'd0,  32'd3,        32'd4,        32'd7});
    vt.push_back('{2'b01, 6'd0,  32'd10,       32'd3,        32'd7});
    vt.push_back('{2'b11, 6'd0,  32'hF0,       32'h3C,       32'h30});
    vt.push_back('{2'b10, F_ADD, 32'hFFFFFFFF, 32'd1,        32'd0});
    vt.push_back('{2'b10, F_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00});
    vt.push_back('{2'b10, F_OR,  32'hF0,       32'h0F,       32'hFF});
    vt.push_back('{2'b10, F_SLT, 32'd1,        32'hFFFFFFFF, 32'd0});
    vt.push_back('{2'b10, F_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1});
    vt.push_back('{2'b10, F_SRL, 32'h1234,     32'd32,       32'h1234});
    vt.push_back('{2'b10, F_SLL, 32'h00ABCDEF, 32'hFFFFFFE0, 32'h00ABCDEF});
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].f, vt[i].xa, vt[i].xb);
      wait_done(0, lat, nb);
      check($sformatf("v%0d_lat", i), lat, 1);
      check($sformatf("v%0d_res", i), result, vt[i].exp);
      check($sformatf("v%0d_zero", i), zero, vt[i].exp == 0);
      check($sformatf("v%0d_ill", i), illegal, 0);
    end

    issue(2'b10, F_SRL, 32'h80000000, 32'h00000024);
    wait_done(0, lat, nb);
    check("srl_lat", lat, 5);
    check("srl_busy", nb, 4);
    check("srl_res", result, 32'h08000000);

    issue(2'b10, F_MUL, 32'hFFFFFFFF, 32'd3);
    wait_done(5, lat, nb);
    check("mul_lat", lat, 33);
    check("mul_busy", nb, 32);
    check("mul_res", result, 32'hFFFFFFFD);
    @(negedge clk);
    check("mul_no_requeue_done", done, 0);
    check("mul_no_requeue_busy", busy, 0);

    issue(2'b10, 6'b111111, 32'd9, 32'd9);
    wait_done(0, lat, nb);
    check("ill_lat", lat, 1);
    check("ill_flag", illegal, 1);
    check("ill_res", result, 0);
    check("ill_zero", zero, 1);
    issue(2'b00, 6'd0, 32'd0, 32'd0);
    wait_done(0, lat, nb);
    check("clr_ill", illegal, 0);
    check("clr_zero", zero, 1);

    issue(2'b10, F_SLL, 32'd1, 32'd3);
    wait_done(0, lat, nb);
    check("sll_lat", lat, 4);
    check("sll_res", result, 32'd8);

    issue(2'b10, F_MUL, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    check("mul2_busy", busy, 1);
    reset = 1'b1;
    start = 1'b1; aluop = 2'b00; a = 32'd4; b = 32'd4;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", result, 0);
    check("abort_zero", zero, 1);
    reset = 1'b0;
    start = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    issue(2'b10, F_SLT, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    check("slt_done", done, 1);
    check("slt_res", result, 1);
    start = 1'b1; aluop = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_res", result, 5);
    @(negedge clk);
    check("b2b_idle", done, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
